// File: rtl/spi_rd_sequencer.sv
// rtl/spi_rd_sequencer.sv - multi-byte SPI read sequencer packing bytes into words behind a FWFT FIFO
module spi_rd_sequencer #(
   parameter int unsigned NUM_BYTES  = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  SCLK_DIV   = 8'd4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   output logic                            busy,
   output logic [7:0]                      rx_sclk_divider,
   output logic                            rx_rd_en,
   input  logic                            rx_csn,
   input  logic                            rx_rd_done,
   input  logic [7:0]                      rx_rd_data,
   output logic                            word_valid,
   output logic [8*NUM_BYTES-1:0]          word_data,
   input  logic                            word_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow,
   input  logic                            clr_overflow
);

   localparam int unsigned W  = 8 * NUM_BYTES;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_CSN_HIGH,
      S_WAIT_DONE,
      S_PUSH
   } state_e;

   state_e          state_q;
   logic [3:0]      byte_cnt_q;
   logic [W-1:0]    assy_q;
   logic [W-1:0]    assy_shift;
   logic            busy_q;
   logic            rd_en_q;
   logic            last_byte;

   logic [W-1:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [LW-1:0]   level_q;
   logic            ovf_q;
   logic            full;
   logic            pop;
   logic            push;
   logic            drop;

   // New byte enters at the LSB so the first byte of a word ends up in the MSB byte.
   generate
      if (NUM_BYTES == 1) begin : g_single
         assign assy_shift = rx_rd_data;
      end else begin : g_multi
         assign assy_shift = {assy_q[W-9:0], rx_rd_data};
      end
   endgenerate

   assign last_byte = (byte_cnt_q == 4'(NUM_BYTES - 1));

   // Read sequencer: request a byte, wait for the receiver to commit and finish, repeat per byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= '0;
         assy_q     <= '0;
         busy_q     <= 1'b0;
         rd_en_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_REQ;
                  byte_cnt_q <= '0;
                  assy_q     <= '0;
                  busy_q     <= 1'b1;
                  rd_en_q    <= 1'b1;
               end
            end
            S_REQ: begin
               // Receiver pulls csn low once it has taken the request.
               if (!rx_csn) begin
                  state_q <= S_WAIT_DONE;
                  rd_en_q <= 1'b0;
               end
            end
            S_WAIT_DONE: begin
               if (rx_rd_done) begin
                  assy_q     <= assy_shift;
                  byte_cnt_q <= byte_cnt_q + 4'd1;
                  state_q    <= last_byte ? S_PUSH : S_WAIT_CSN_HIGH;
               end
            end
            S_WAIT_CSN_HIGH: begin
               // Hold off until the current transfer closes so one transfer is never requested twice.
               if (rx_csn) begin
                  state_q <= S_REQ;
                  rd_en_q <= 1'b1;
               end
            end
            S_PUSH: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               rd_en_q <= 1'b0;
            end
         endcase
      end
   end

   // A concurrent pop frees a slot, so a push into a full FIFO still lands when the head leaves.
   always_comb begin
      full = (level_q == LW'(FIFO_DEPTH));
      pop  = (level_q != '0) && word_ready;
      push = (state_q == S_PUSH) && (!full || pop);
      drop = (state_q == S_PUSH) && full && !pop;
   end

   // FIFO storage carries no reset; emptiness is tracked by the level counter alone.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem_q[wr_ptr_q] <= assy_q;
      end
   end

   // FIFO pointers, fill level and sticky overflow flag (setting beats clearing).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            level_q <= level_q + LW'(1);
         end else if (pop && !push) begin
            level_q <= level_q - LW'(1);
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (clr_overflow) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign busy            = busy_q;
   assign rx_rd_en        = rd_en_q;
   assign rx_sclk_divider = SCLK_DIV;
   assign word_valid      = (level_q != '0);
   assign word_data       = word_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level      = level_q;
   assign overflow        = ovf_q;

endmodule

// File: tb/tb_spi_rd_sequencer.sv
// tb/tb_spi_rd_sequencer.sv - randomized self-checking bench for spi_rd_sequencer
module tb_spi_rd_sequencer;

   localparam int NB    = 2;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic [7:0]  rx_sclk_divider;
   logic        rx_rd_en;
   logic        rx_csn;
   logic        rx_rd_done;
   logic [7:0]  rx_rd_data;
   logic        word_valid;
   logic [15:0] word_data;
   logic        word_ready;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        clr_overflow;

   int          n_checks;
   int          n_fail;
   logic [7:0]  byte_q [$];
   logic [15:0] model_q [$];
   bit          exp_ovf;
   bit          noise;
   int          fixed_dly;
   int          rd_en_rises;
   bit          prev_en;

   spi_rd_sequencer #(
      .NUM_BYTES  (NB),
      .FIFO_DEPTH (DEPTH),
      .SCLK_DIV   (8'd4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .busy            (busy),
      .rx_sclk_divider (rx_sclk_divider),
      .rx_rd_en        (rx_rd_en),
      .rx_csn          (rx_csn),
      .rx_rd_done      (rx_rd_done),
      .rx_rd_data      (rx_rd_data),
      .word_valid      (word_valid),
      .word_data       (word_data),
      .word_ready      (word_ready),
      .fifo_level      (fifo_level),
      .overflow        (overflow),
      .clr_overflow    (clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock, then sample just after the edge; also counts rx_rd_en request phases.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (rx_rd_en === 1'b1 && !prev_en) rd_en_rises++;
      prev_en = (rx_rd_en === 1'b1);
   endtask

   // Receiver model: commit with csn low, return one byte after a delay, then release csn.
   initial begin : receiver
      int d;
      rx_csn     = 1'b1;
      rx_rd_done = 1'b0;
      rx_rd_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rx_rd_en === 1'b1 && rx_csn) begin
            if (noise) begin
               rx_rd_data = 8'hEE;
               rx_rd_done = 1'b1;
               @(negedge clk);
               rx_rd_done = 1'b0;
            end
            rx_csn = 1'b0;
            d = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 3));
            repeat (d) @(negedge clk);
            rx_rd_data = (byte_q.size() > 0) ? byte_q.pop_front() : 8'h00;
            rx_rd_done = 1'b1;
            @(negedge clk);
            rx_rd_done = 1'b0;
            d = int'($urandom_range(0, 2));
            repeat (d) @(negedge clk);
            rx_csn = 1'b1;
         end
      end
   end

   task automatic run_word(input logic [7:0] b0, input logic [7:0] b1,
                           input bit rdy_push, input bit clr_push, input bit noisy);
      int          guard;
      int          dones;
      int          r0;
      bit          was_empty;
      bit          drop;
      logic [15:0] w;
      w = {b0, b1};
      guard = 0;
      while (!rx_csn && guard < 50) begin
         cycle();
         guard++;
      end
      check_eq("rx_idle_wait", 32'(guard < 50), 1);
      byte_q.push_back(b0);
      byte_q.push_back(b1);
      noise     = noisy;
      r0        = rd_en_rises;
      was_empty = (model_q.size() == 0);
      start = 1'b1;
      cycle();
      start = 1'b0;
      check_eq("busy_after_start", busy, 1);
      dones = 0;
      guard = 0;
      while (dones < NB && guard < 300) begin
         start = noisy && (guard % 4 == 2);
         cycle();
         guard++;
         if (rx_rd_done && !rx_csn) dones++;
      end
      start = 1'b0;
      check_eq("word_timeout", 32'(guard < 300), 1);
      check_eq("busy_in_push", busy, 1);
      if (was_empty) check_eq("valid_before_push", word_valid, 0);
      if (rdy_push && model_q.size() > 0) check_eq("head_at_push", word_data, model_q[0]);
      word_ready   = rdy_push;
      clr_overflow = clr_push;
      cycle();
      word_ready   = 1'b0;
      clr_overflow = 1'b0;
      if (rdy_push && model_q.size() > 0) void'(model_q.pop_front());
      drop = (model_q.size() >= DEPTH);
      if (drop) begin
         exp_ovf = 1'b1;
      end else begin
         model_q.push_back(w);
         if (clr_push) exp_ovf = 1'b0;
      end
      check_eq("busy_after_push", busy, 0);
      if (was_empty) begin
         check_eq("latency_valid", word_valid, 1);
         check_eq("latency_data", word_data, w);
      end
      check_eq("level", fifo_level, model_q.size());
      check_eq("overflow", overflow, exp_ovf);
      check_eq("rd_en_phases", rd_en_rises - r0, NB);
      noise = 1'b0;
   endtask

   task automatic drain_one(input string tag);
      logic [15:0] e;
      e = model_q.pop_front();
      check_eq({tag, "_valid"}, word_valid, 1);
      check_eq({tag, "_data"}, word_data, e);
      word_ready = 1'b1;
      cycle();
      word_ready = 1'b0;
      check_eq({tag, "_level"}, fifo_level, model_q.size());
   endtask

   initial begin : main
      int guard;
      int r0;
      int n;
      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      start        = 1'b0;
      word_ready   = 1'b0;
      clr_overflow = 1'b0;
      noise        = 1'b0;
      fixed_dly    = 0;
      exp_ovf      = 1'b0;
      rd_en_rises  = 0;
      prev_en      = 1'b0;

      repeat (3) cycle();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rd_en", rx_rd_en, 0);
      check_eq("rst_valid", word_valid, 0);
      check_eq("rst_data", word_data, 0);
      check_eq("rst_level", fifo_level, 0);
      check_eq("rst_ovf", overflow, 0);
      check_eq("sclk_div", rx_sclk_divider, 8'd4);
      rst_n = 1'b1;
      cycle();

      // Basic two-byte word, first byte in the MSB.
      run_word(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
      check_eq("t1_word", word_data, 16'hA53C);
      drain_one("t1_pop");

      // Fill, overflow on the fifth word, drain in order.
      for (int i = 1; i <= 5; i++) run_word(8'(i), 8'(i), 1'b0, 1'b0, 1'b0);
      check_eq("t2_level_full", fifo_level, 4);
      check_eq("t2_overflow", overflow, 1);
      for (int i = 0; i < 4; i++) drain_one("t2_drain");

      clr_overflow = 1'b1;
      cycle();
      clr_overflow = 1'b0;
      exp_ovf = 1'b0;
      check_eq("clr_ovf", overflow, 0);

      // Full FIFO with a pop in the push cycle: both happen, no overflow.
      for (int i = 0; i < 4; i++) run_word(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      run_word(8'h11, 8'h11, 1'b1, 1'b0, 1'b0);
      check_eq("t3_level", fifo_level, 4);
      check_eq("t3_ovf", overflow, 0);
      for (int i = 0; i < 3; i++) drain_one("t3_drain");
      check_eq("t3_last", word_data, 16'h1111);
      drain_one("t3_drain");

      // Stray start pulses and a spurious rd_done while requesting are ignored.
      run_word(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1);
      check_eq("t4_word", word_data, 16'hA53C);
      repeat (5) cycle();
      check_eq("t4_idle", busy, 0);
      check_eq("t4_level", fifo_level, 1);
      drain_one("t4_pop");

      // Drop while clearing: set wins; clear alone afterwards works.
      for (int i = 0; i < 5; i++) run_word(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      check_eq("t6_ovf_set", overflow, 1);
      run_word(8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);
      check_eq("t6_ovf_set_wins", overflow, 1);
      clr_overflow = 1'b1;
      cycle();
      clr_overflow = 1'b0;
      exp_ovf = 1'b0;
      check_eq("t6_ovf_cleared", overflow, 0);
      drain_one("t6_drain");
      drain_one("t6_drain");

      // Reset while waiting for the second byte, with two words buffered.
      guard = 0;
      while (!rx_csn && guard < 50) begin
         cycle();
         guard++;
      end
      byte_q.push_back(8'($urandom));
      byte_q.push_back(8'($urandom));
      fixed_dly = 6;
      r0 = rd_en_rises;
      start = 1'b1;
      cycle();
      start = 1'b0;
      guard = 0;
      while (!((rd_en_rises - r0) == 2 && !rx_rd_en) && guard < 100) begin
         cycle();
         guard++;
      end
      check_eq("t5_reach_wait_done", 32'(guard < 100), 1);
      check_eq("t5_busy_before", busy, 1);
      check_eq("t5_level_before", fifo_level, 2);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check_eq("t5_busy", busy, 0);
      check_eq("t5_rd_en", rx_rd_en, 0);
      check_eq("t5_valid", word_valid, 0);
      check_eq("t5_data", word_data, 0);
      check_eq("t5_level", fifo_level, 0);
      check_eq("t5_ovf", overflow, 0);
      model_q.delete();
      exp_ovf   = 1'b0;
      fixed_dly = 0;
      repeat (20) cycle();
      run_word(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      drain_one("t5_clean");

      // Randomized bursts of words against the reference queue.
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) run_word(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
         for (int i = 0; i < n; i++) drain_one("rnd_drain");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
